// File: rtl/arb_pkg.sv
// Shared definitions for the 4-requester arbiter.
// Contents: requester count and ID width, the FSM state type, and the
// onehot() helper that turns a binary requester ID into a grant vector.
package arb_pkg;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned ID_W    = 2;
    localparam int unsigned HOLD_W  = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // Binary requester ID to one-hot grant vector.
    function automatic logic [NUM_REQ-1:0] onehot(input logic [ID_W-1:0] id);
        return NUM_REQ'(1) << id;
    endfunction

endpackage

// File: rtl/arb_prio_pick.sv
// Rotating priority pick (combinational).
// Requests are masked, rotated so that the candidate searched first lands at
// the top index, encoded highest-index-wins, then rotated back.
// With base=B the search order is B-1, B-2, B-3, B (mod 4).
// Ports:
//   req   [3:0] : raw requests
//   mask  [3:0] : requesters excluded from this decision
//   base  [1:0] : rotation amount (last owner, or 0 for fixed priority)
//   id    [1:0] : winning requester (0 when no winner)
//   valid       : a winner exists
module arb_prio_pick
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] mask,
    input  logic [ID_W-1:0]    base,
    output logic [ID_W-1:0]    id,
    output logic               valid
);

    logic [NUM_REQ-1:0] w_eff;
    logic [NUM_REQ-1:0] w_rot;
    logic [ID_W-1:0]    w_enc;
    logic               w_any;

    assign w_eff = req & ~mask;

    // Rotate: position k of w_rot holds requester (base + k) mod 4.
    always_comb begin
        w_rot = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_rot[k] = w_eff[ID_W'(base + ID_W'(k))];
        end
    end

    // Highest-index-wins encode (later hits overwrite earlier ones).
    always_comb begin
        w_enc = '0;
        w_any = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_rot[k]) begin
                w_enc = ID_W'(k);
                w_any = 1'b1;
            end
        end
    end

    // Un-rotate back to a requester index.
    assign id    = w_any ? ID_W'(base + w_enc) : '0;
    assign valid = w_any;

endmodule

// File: rtl/req_arbiter_4.sv
// Hold-until-release arbiter sharing one resource among 4 requesters.
// Optional forced revoke after MAX_HOLD grant cycles when ARB_TIMEOUT_EN
// is defined; otherwise grants are held indefinitely and timeout is 0.
// Ports:
//   clk          : rising-edge clock
//   rst          : synchronous active-high reset
//   req    [3:0] : per-requester request, held for the whole transaction
//   gnt    [3:0] : registered one-hot grant, zero when idle
//   gnt_id [1:0] : binary owner index, 0 when idle
//   busy         : a grant is active
//   timeout      : one-cycle pulse on forced revoke
module req_arbiter_4
    import arb_pkg::*;
#(
    parameter int unsigned ROUND_ROBIN = 1,
    parameter int unsigned MAX_HOLD    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_id,
    output logic               busy,
    output logic               timeout
);

    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("req_arbiter_4: MAX_HOLD must be within 2..255");
    end

    arb_state_e         r_state,      w_state_nxt;
    logic [NUM_REQ-1:0] r_gnt,        w_gnt_nxt;
    logic [ID_W-1:0]    r_gnt_id,     w_id_nxt;
    logic [ID_W-1:0]    r_last_owner, w_last_nxt;
    logic               r_busy,       w_busy_nxt;
    logic               r_timeout,    w_timeout_nxt;
`ifdef ARB_TIMEOUT_EN
    logic [HOLD_W-1:0]  r_hold_cnt,   w_hold_nxt;
`endif

    logic               w_revoke_c;
    logic               w_arb;
    logic [NUM_REQ-1:0] w_mask;
    logic [ID_W-1:0]    w_base;
    logic [ID_W-1:0]    w_pick_id;
    logic               w_pick_vld;

    // Owner still requesting on its final allowed cycle: revoke at this edge.
`ifdef ARB_TIMEOUT_EN
    assign w_revoke_c = (r_state == GRANT) && req[r_gnt_id] &&
                        (r_hold_cnt == HOLD_W'(MAX_HOLD - 1));
`else
    assign w_revoke_c = 1'b0;
`endif

    // A revoked owner may not win the re-arbitration on the same edge.
    assign w_mask = w_revoke_c ? onehot(r_gnt_id) : '0;
    assign w_base = (ROUND_ROBIN != 0) ? r_last_owner : '0;

    arb_prio_pick u_pick (
        .req   (req),
        .mask  (w_mask),
        .base  (w_base),
        .id    (w_pick_id),
        .valid (w_pick_vld)
    );

    // Next-state and registered-output logic.
    always_comb begin
        w_state_nxt   = r_state;
        w_gnt_nxt     = r_gnt;
        w_id_nxt      = r_gnt_id;
        w_last_nxt    = r_last_owner;
        w_busy_nxt    = r_busy;
        w_timeout_nxt = 1'b0;
        w_arb         = 1'b0;
`ifdef ARB_TIMEOUT_EN
        w_hold_nxt    = r_hold_cnt;
`endif

        case (r_state)
            IDLE: begin
                w_arb = 1'b1;
            end
            GRANT: begin
                if (!req[r_gnt_id]) begin
                    w_arb = 1'b1;
                end else if (w_revoke_c) begin
                    w_arb         = 1'b1;
                    w_timeout_nxt = 1'b1;
                end else begin
`ifdef ARB_TIMEOUT_EN
                    if (r_hold_cnt != '1) begin
                        w_hold_nxt = r_hold_cnt + HOLD_W'(1);
                    end
`endif
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // Release/revoke/idle all re-arbitrate on the same edge (no bubble).
        if (w_arb) begin
            if (w_pick_vld) begin
                w_state_nxt = GRANT;
                w_gnt_nxt   = onehot(w_pick_id);
                w_id_nxt    = w_pick_id;
                w_last_nxt  = w_pick_id;
                w_busy_nxt  = 1'b1;
            end else begin
                w_state_nxt = IDLE;
                w_gnt_nxt   = '0;
                w_id_nxt    = '0;
                w_busy_nxt  = 1'b0;
            end
`ifdef ARB_TIMEOUT_EN
            w_hold_nxt = '0;
`endif
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_gnt        <= '0;
            r_gnt_id     <= '0;
            r_last_owner <= '0;
            r_busy       <= 1'b0;
            r_timeout    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            r_hold_cnt   <= '0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_gnt        <= w_gnt_nxt;
            r_gnt_id     <= w_id_nxt;
            r_last_owner <= w_last_nxt;
            r_busy       <= w_busy_nxt;
            r_timeout    <= w_timeout_nxt;
`ifdef ARB_TIMEOUT_EN
            r_hold_cnt   <= w_hold_nxt;
`endif
        end
    end

    assign gnt     = r_gnt;
    assign gnt_id  = r_gnt_id;
    assign busy    = r_busy;
    assign timeout = r_timeout;

endmodule

// File: tb/tb_req_arbiter_4.sv
// Bench for req_arbiter_4: round-robin and fixed-priority instances share one
// stimulus stream; a behavioural model tracks each instance every cycle.
module tb_req_arbiter_4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;

    always #5 clk = ~clk;

    logic [3:0] gnt_rr, gnt_fp;
    logic [1:0] id_rr, id_fp;
    logic       busy_rr, busy_fp, to_rr, to_fp;

    req_arbiter_4 #(.ROUND_ROBIN(1), .MAX_HOLD(16)) dut_rr (
        .clk(clk), .rst(rst), .req(req),
        .gnt(gnt_rr), .gnt_id(id_rr), .busy(busy_rr), .timeout(to_rr));

    req_arbiter_4 #(.ROUND_ROBIN(0), .MAX_HOLD(16)) dut_fp (
        .clk(clk), .rst(rst), .req(req),
        .gnt(gnt_fp), .gnt_id(id_fp), .busy(busy_fp), .timeout(to_fp));

`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
    logic [3:0] gnt_to;
    logic [1:0] id_to;
    logic       busy_to, to_to;
    req_arbiter_4 #(.ROUND_ROBIN(1), .MAX_HOLD(4)) dut_to (
        .clk(clk), .rst(rst), .req(req),
        .gnt(gnt_to), .gnt_id(id_to), .busy(busy_to), .timeout(to_to));
`else
    localparam bit TO_EN = 1'b0;
`endif

    int n_checks = 0;
    int n_err    = 0;

    // Model state: owner -1 means idle.
    typedef struct {
        int owner;
        int last;
        int hold;
        bit to;
    } model_t;

    model_t m_rr, m_fp;
`ifdef ARB_TIMEOUT_EN
    model_t m_to;
`endif

    function automatic int pick(input logic [3:0] r, input bit rr, input int last);
        int c;
        if (rr) begin
            for (int i = 1; i <= 4; i++) begin
                c = (last + 4 - i) % 4;
                if (r[c]) return c;
            end
        end else begin
            for (int j = 3; j >= 0; j--) begin
                if (r[j]) return j;
            end
        end
        return -1;
    endfunction

    function automatic model_t step_model(input model_t m, input logic rs, input logic [3:0] r,
                                          input bit rr, input bit to_en, input int max_hold);
        model_t     n;
        bit         arb;
        logic [3:0] cand;
        int         w;
        n    = m;
        n.to = 1'b0;
        if (rs) begin
            n.owner = -1; n.last = 0; n.hold = 0;
            return n;
        end
        arb  = 1'b0;
        cand = r;
        if (m.owner < 0) arb = 1'b1;
        else if (!r[m.owner]) arb = 1'b1;
        else if (to_en && m.hold == max_hold - 1) begin
            arb = 1'b1; n.to = 1'b1; cand[m.owner] = 1'b0;
        end else n.hold = m.hold + 1;
        if (arb) begin
            w       = pick(cand, rr, m.last);
            n.owner = w;
            n.hold  = 0;
            if (w >= 0) n.last = w;
        end
        return n;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_model(input string tag, input logic [3:0] g, input logic [1:0] id,
                             input logic b, input logic to, input model_t m);
        logic [3:0] eg;
        eg = (m.owner < 0) ? 4'b0000 : (4'b0001 << m.owner);
        chk({tag, " gnt"}, 32'(g), 32'(eg));
        chk({tag, " gnt_id"}, 32'(id), (m.owner < 0) ? 32'd0 : 32'(m.owner));
        chk({tag, " busy"}, 32'(b), 32'(m.owner >= 0));
        chk({tag, " timeout"}, 32'(to), 32'(m.to));
        chk({tag, " onehot"}, 32'($countones(g) <= 1), 32'd1);
    endtask

    // One clock: DUTs and models consume the same req/rst; fixed-priority
    // (and timeout) instances are always checked against the model.
    task automatic tick();
        @(posedge clk);
        m_rr = step_model(m_rr, rst, req, 1'b1, TO_EN, 16);
        m_fp = step_model(m_fp, rst, req, 1'b0, TO_EN, 16);
`ifdef ARB_TIMEOUT_EN
        m_to = step_model(m_to, rst, req, 1'b1, 1'b1, 4);
`endif
        #1;
        cmp_model("fp", gnt_fp, id_fp, busy_fp, to_fp, m_fp);
`ifdef ARB_TIMEOUT_EN
        cmp_model("to", gnt_to, id_to, busy_to, to_to, m_to);
`endif
    endtask

    typedef struct packed {
        logic       rst;
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] id;
        logic       busy;
    } vec_t;

    vec_t tbl [16];

    logic [3:0] fair_req [5] = '{4'b1111, 4'b0111, 4'b1011, 4'b1101, 4'b1110};
    int         fair_id  [5] = '{3, 2, 1, 0, 3};
    logic [3:0] fp_req   [6] = '{4'b1011, 4'b1011, 4'b0011, 4'b1001, 4'b1011, 4'b0011};
    int         fp_id    [6] = '{3, 3, 1, 3, 3, 1};

    initial begin
        rst = 1'b1;
        req = 4'b0000;
        m_rr = '{-1, 0, 0, 1'b0};
        m_fp = '{-1, 0, 0, 1'b0};
`ifdef ARB_TIMEOUT_EN
        m_to = '{-1, 0, 0, 1'b0};
`endif

        // Round-robin instance, expected values derived by hand.
        tbl[0]  = '{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0};
        tbl[1]  = '{1'b0, 4'b0101, 4'b0100, 2'd2, 1'b1};
        tbl[2]  = '{1'b0, 4'b0101, 4'b0100, 2'd2, 1'b1};
        tbl[3]  = '{1'b0, 4'b0001, 4'b0001, 2'd0, 1'b1};
        tbl[4]  = '{1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1};
        tbl[5]  = '{1'b0, 4'b1110, 4'b1000, 2'd3, 1'b1};
        tbl[6]  = '{1'b0, 4'b0111, 4'b0100, 2'd2, 1'b1};
        tbl[7]  = '{1'b0, 4'b1011, 4'b0010, 2'd1, 1'b1};
        tbl[8]  = '{1'b0, 4'b1000, 4'b1000, 2'd3, 1'b1};
        tbl[9]  = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0};
        tbl[10] = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0};
        tbl[11] = '{1'b0, 4'b0010, 4'b0010, 2'd1, 1'b1};
        tbl[12] = '{1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0};
        tbl[13] = '{1'b0, 4'b1111, 4'b1000, 2'd3, 1'b1};
        tbl[14] = '{1'b0, 4'b1111, 4'b1000, 2'd3, 1'b1};
        tbl[15] = '{1'b0, 4'b0111, 4'b0100, 2'd2, 1'b1};

        for (int i = 0; i < 16; i++) begin
            rst = tbl[i].rst;
            req = tbl[i].req;
            tick();
            chk($sformatf("tbl%0d gnt", i), 32'(gnt_rr), 32'(tbl[i].gnt));
            chk($sformatf("tbl%0d gnt_id", i), 32'(id_rr), 32'(tbl[i].id));
            chk($sformatf("tbl%0d busy", i), 32'(busy_rr), 32'(tbl[i].busy));
            chk($sformatf("tbl%0d timeout", i), 32'(to_rr), 32'd0);
        end

        // Round-robin fairness: back-to-back handover, no idle cycle.
        rst = 1'b1; req = 4'b0000;
        tick();
        chk("fair reset gnt", 32'(gnt_rr), 32'd0);
        chk("fair reset busy", 32'(busy_rr), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            req = fair_req[i];
            tick();
            chk($sformatf("fair%0d gnt_id", i), 32'(id_rr), 32'(fair_id[i]));
            chk($sformatf("fair%0d gnt", i), 32'(gnt_rr), 32'(4'b0001 << fair_id[i]));
            chk($sformatf("fair%0d busy", i), 32'(busy_rr), 32'd1);
        end

        // Fixed priority: 3 wins whenever req[3] is sampled high.
        rst = 1'b1; req = 4'b0000;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            req = fp_req[i];
            tick();
            chk($sformatf("fixed%0d gnt_id", i), 32'(id_fp), 32'(fp_id[i]));
            chk($sformatf("fixed%0d gnt", i), 32'(gnt_fp), 32'(4'b0001 << fp_id[i]));
        end

        // Long hold of requester 2 with requester 0 pending.
        rst = 1'b1; req = 4'b0000;
        tick();
        rst = 1'b0;
        req = 4'b0101;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk($sformatf("hold%0d rr gnt", i), 32'(gnt_rr), 32'(4'b0100));
            chk($sformatf("hold%0d rr timeout", i), 32'(to_rr), 32'd0);
`ifdef ARB_TIMEOUT_EN
            chk($sformatf("hold%0d to gnt", i), 32'(gnt_to), (i < 4) ? 32'(4'b0100) : 32'(4'b0001));
            chk($sformatf("hold%0d to timeout", i), 32'(to_to), (i == 4) ? 32'd1 : 32'd0);
`endif
        end

        // Randomized traffic with occasional resets, round-robin vs model.
        for (int i = 0; i < 500; i++) begin
            rst = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 2) == 0) req = 4'($urandom);
            else if (m_rr.owner >= 0 && $urandom_range(0, 3) == 0) req[m_rr.owner] = 1'b0;
            tick();
            cmp_model("rr", gnt_rr, id_rr, busy_rr, to_rr, m_rr);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
